// File: rtl/prio_rr_arbiter_lock.sv
// Registered N-way arbiter with LSB/MSB/round-robin modes.
// The grant stays locked until last beat, owner abort or hold timeout.
module prio_rr_arbiter_lock #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  localparam int IW      = (N > 2) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [1:0]    mode,
  input  logic          ack,
  input  logic          last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid,
  output logic          timeout
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW:0]   N_W      = (IW + 1)'(N);
  localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          to_q, to_d;

  logic [IW-1:0]  win;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    off;
  logic [IW:0]    sum;
  logic           rel_a, rel_b, rel_c;

  always_comb begin : pick
    win = '0;
    off = '0;
    sum = '0;
    dbl = {req, req} >> ptr_q;
    rot = dbl[N-1:0];
    case (mode)
      2'd0: begin
        for (int i = N - 1; i >= 0; i--)
          if (req[i]) win = IW'(i);
      end
      2'd1: begin
        for (int i = 0; i < N; i++)
          if (req[i]) win = IW'(i);
      end
      default: begin
        // rot is req rotated so bit 0 is rr_ptr
        for (int k = N - 1; k >= 0; k--)
          if (rot[k]) off = (IW + 1)'(k);
        sum = {1'b0, ptr_q} + off;
        if (sum >= N_W) sum = sum - N_W;
        win = sum[IW-1:0];
      end
    endcase
  end

  always_comb begin : fsm
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    to_d    = 1'b0;
    rel_a   = ack & last;
    rel_b   = !req[idx_q];
    rel_c   = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = LOCK;
          gnt_d   = ONE << win;
          idx_d   = win;
          hold_d  = HW'(1);
        end
      end
      LOCK: begin
        if (rel_a || rel_b || rel_c) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          hold_d  = '0;
          to_d    = !rel_a && !rel_b;
          ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_prio_rr_arbiter_lock.sv
// Scoreboard bench for prio_rr_arbiter_lock (N=8, MAX_HOLD=4).
// Stimulus pushes expected grants; a negedge monitor checks them.
module tb_prio_rr_arbiter_lock;

  localparam int N  = 8;
  localparam int MH = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [1:0]   mode;
  logic         ack;
  logic         last;
  logic [N-1:0] gnt;
  logic [2:0]   gnt_idx;
  logic         gnt_valid;
  logic         timeout;

  prio_rr_arbiter_lock #(.N(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
    .ack(ack), .last(last), .gnt(gnt), .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid), .timeout(timeout)
  );

  typedef struct {
    int idx;
    int len;
    bit to;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input int len, input bit to);
    exp_t e;
    e.idx = idx;
    e.len = len;
    e.to  = to;
    exp_q.push_back(e);
  endtask

  // Monitor: grant rise compares owner, grant fall compares length/timeout.
  bit in_g = 1'b0;
  int g_len = 0;
  int g_idx = 0;

  always @(negedge clk) begin
    bit fall;
    exp_t e;
    if (!rst_n) begin
      if (in_g && exp_q.size() > 0) void'(exp_q.pop_front());
      in_g = 1'b0;
    end else begin
      fall = in_g && !gnt_valid;
      chk("onehot", int'($onehot0(gnt)), 1);
      chk("valid_eq_or", int'(gnt_valid), int'(|gnt));
      if (timeout && !fall) chk("timeout_stray", 1, 0);
      if (!in_g && gnt_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", int'(gnt_idx), -1);
        end else begin
          chk("grant_idx", int'(gnt_idx), exp_q[0].idx);
          chk("grant_vec", int'(gnt), 1 << exp_q[0].idx);
        end
        in_g  = 1'b1;
        g_len = 1;
        g_idx = int'(gnt_idx);
      end else if (in_g && gnt_valid) begin
        g_len++;
        if (int'(gnt_idx) != g_idx) chk("grant_stable", int'(gnt_idx), g_idx);
      end else if (fall) begin
        in_g = 1'b0;
        chk("idle_idx", int'(gnt_idx), 0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("grant_len", g_len, e.len);
          chk("timeout", int'(timeout), int'(e.to));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    mode  = 2'd0;
    ack   = 1'b0;
    last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_valid", int'(gnt_valid), 0);
    chk("rst_idx", int'(gnt_idx), 0);
    chk("rst_timeout", int'(timeout), 0);
    rst_n = 1'b1;
    cyc();

    // LSB-first, ack without last keeps the lock
    mode = 2'd0; req = 8'b1010_0100; push(2, 3, 0);
    cyc();
    ack = 1'b1;
    repeat (2) cyc();
    last = 1'b1;
    cyc();
    ack = 1'b0; last = 1'b0; req = '0;
    cyc();

    // MSB-first, higher requester and mode change ignored in LOCK
    mode = 2'd1; req = 8'b0001_0011; push(4, 2, 0);
    cyc();
    req = 8'b1001_0011; mode = 2'd0;
    cyc();
    ack = 1'b1; last = 1'b1;
    cyc();
    ack = 1'b0; last = 1'b0; req = '0;
    cyc();

    // owner abort on idx 5 -> rr_ptr becomes 6
    mode = 2'd0; req = 8'b0010_0000; push(5, 2, 0);
    repeat (2) cyc();
    req = '0;
    cyc();
    cyc();

    // round-robin wrap search from 6 -> idx 1, rr_ptr becomes 2
    mode = 2'd2; req = 8'b0000_0010; push(1, 1, 0);
    ack = 1'b1; last = 1'b1;
    repeat (2) cyc();
    ack = 1'b0; last = 1'b0; req = '0;
    cyc();

    // rr_ptr == 2 picks idx 2 over idx 1
    req = 8'b0000_0110; push(2, 1, 0);
    ack = 1'b1; last = 1'b1;
    repeat (2) cyc();
    ack = 1'b0; last = 1'b0; req = '0;
    cyc();

    // hold timeout after 4 LOCK cycles
    mode = 2'd0; req = 8'b0000_1000; push(3, 4, 1);
    repeat (5) cyc();
    req = '0;
    repeat (2) cyc();

    // ack&last on the limit cycle wins over timeout
    req = 8'b0000_1000; push(3, 4, 0);
    repeat (4) cyc();
    ack = 1'b1; last = 1'b1;
    cyc();
    ack = 1'b0; last = 1'b0; req = '0;
    repeat (2) cyc();

    // async reset mid-LOCK
    mode = 2'd2; req = 8'b0001_0001; push(4, 0, 0);
    repeat (2) cyc();
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_valid", int'(gnt_valid), 0);
    chk("midrst_idx", int'(gnt_idx), 0);
    chk("midrst_timeout", int'(timeout), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // round-robin sweep from idx 0, one beat per grant
    req = 8'hFF; ack = 1'b1; last = 1'b1;
    for (int k = 0; k < 9; k++) push(k % N, 1, 0);
    repeat (18) cyc();
    req = '0; ack = 1'b0; last = 1'b0;
    repeat (3) cyc();

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prio_rr_arbiter_lock.md
Name: prio_rr_arbiter_lock

Overview:
- N-requester arbiter selecting one of three priority modes at run time: fixed LSB-first, fixed MSB-first, or round-robin.
- The grant is registered and locked for a multi-beat transaction until the owner signals last, drops its request, or hits a hold timeout.
- Successor to the combinational fixed-priority grant logic. It sits in front of shared resources such as bus ports and memory banks.

Parameters:
- N, 8, number of requesters (N >= 2).
- MAX_HOLD, 16, maximum cycles a grant may be held; 0 disables the timeout.
- IW, $clog2(N) (minimum 1), width of gnt_idx (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  per-requester request, level-sensitive.
- mode  in  2  0 = LSB highest priority, 1 = MSB highest priority, 2 = round-robin, 3 = treated as 2.
- ack  in  1  resource accepted one beat of the current owner.
- last  in  1  qualifies ack as the final beat; ignored without ack.
- gnt  out  N  one-hot registered grant; all-zero when idle.
- gnt_idx  out  IW  binary index of the owner; 0 when idle.
- gnt_valid  out  1  a grant is active (equals |gnt).
- timeout  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset values (async assert, sync deassert handled externally):
  - gnt = 0, gnt_idx = 0, gnt_valid = 0, timeout = 0.
  - state = IDLE, rr_ptr = 0, hold_cnt = 0.
- FSM states: IDLE and LOCK.
- IDLE:
  - If req != 0, pick a winner per mode, sampled this cycle only.
  - Register gnt, gnt_idx and gnt_valid = 1; go to LOCK.
  - Grant appears one cycle after req is sampled.
  - If req == 0, stay in IDLE with outputs 0.
- Winner selection:
  - Mode 0: lowest set bit.
  - Mode 1: highest set bit.
  - Mode 2: first set bit at or above rr_ptr, searching upward with wrap N-1 -> 0.
  - Ties cannot occur; exactly one winner whenever req != 0.
- LOCK:
  - gnt and gnt_idx stay constant. Changes in req, including higher-priority requesters, and changes in mode have no effect.
  - hold_cnt increments each LOCK cycle, starting at 1 on the first LOCK cycle.
- Release conditions, evaluated every LOCK cycle, first match wins:
  - (a) ack & last.
  - (b) req[gnt_idx] == 0, i.e. owner abort.
  - (c) MAX_HOLD != 0 and hold_cnt == MAX_HOLD; timeout pulses in the following cycle, aligned with gnt clearing.
- On any release:
  - Next cycle gnt = 0, gnt_valid = 0, gnt_idx = 0, state = IDLE, hold_cnt = 0.
  - rr_ptr = (gnt_idx + 1) mod N, updated on every release regardless of mode.
  - One mandatory idle bubble separates consecutive grants, so back-to-back grants are spaced 1 cycle apart, minimum 2 cycles per grant.
- Simultaneous conditions: when ack & last coincide with the hold_cnt limit, (a) wins and timeout stays 0.
- ack without last in LOCK only counts toward nothing except hold_cnt progression; ack in IDLE is ignored.
- Wrap-around: rr_ptr from N-1 goes to 0. The search from rr_ptr wraps cleanly for non-power-of-2 N.
- Reset mid-LOCK: all outputs clear immediately (async); rr_ptr returns to 0.
- Invariant: gnt is always one-hot or zero, and gnt_valid == |gnt.
- gnt[i] = 1 only if req[i] was 1 at the arbitration cycle.

Test Plan:
- N=8, mode=0, req=8'b1010_0100 -> next cycle gnt=8'b0000_0100, gnt_idx=2. Hold ack=0 and req constant: gnt is held. ack=1, last=1 -> gnt=0 the following cycle.
- mode=1, req=8'b0001_0011 -> gnt=8'b0001_0000, gnt_idx=4. Raising req[7] during LOCK does not change gnt.
- mode=2, req=8'hFF held, each grant released by ack&last one cycle after it is issued -> gnt_idx sequence 0,1,2,...,7,0 with gnt_valid toggling 1,0,1,0.
- mode=2 with rr_ptr=6, req=8'b0000_0010 -> gnt_idx=1 (wrap search). After release, rr_ptr=2.
- MAX_HOLD=4, req[3]=1 held, no ack -> gnt_idx=3 for exactly 4 cycles, then gnt=0 with timeout=1 for one cycle. With ack&last in the 4th LOCK cycle -> timeout stays 0.
- Owner abort: granted idx 5 drops req[5] -> gnt clears next cycle. Separately, assert rst_n=0 mid-LOCK -> gnt/gnt_valid/timeout=0 without a clock edge; the first post-reset round-robin grant starts searching from idx 0.
